// File: rtl/shift_pkg.sv
// Shared encodings and FSM state type for the multi-cycle shift engine.
// Used by shift_sequencer and its single-pass datapath shift_step.
package shift_pkg;

    localparam logic [1:0] SEL_LSH = 2'd0;
    localparam logic [1:0] SEL_ASH = 2'd1;
    localparam logic [1:0] SEL_ROT = 2'd2;
    localparam logic [1:0] SEL_ILL = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Purpose: one shift pass of up to bit_size-1 positions, reporting any 1 pushed out of the MSB.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module shift_step
    import shift_pkg::*;
#(
    parameter int bit_size = 4,
    parameter int step_w   = $clog2(bit_size)
) (
    input  logic [bit_size-1:0] acc,
    input  logic [step_w-1:0]   step,
    input  logic                direction,
    input  logic [1:0]          sel,
    output logic [bit_size-1:0] result,
    output logic                lost_one
);

    // Double-width left shift so the bits leaving the MSB end land in the upper half.
    logic [2*bit_size-1:0] left_ext;

    always_comb begin
        left_ext = {{bit_size{1'b0}}, acc} << step;
        result   = acc;
        lost_one = 1'b0;
        case (sel)
            SEL_LSH, SEL_ASH: begin
                if (direction == DIR_LEFT) begin
                    result   = left_ext[bit_size-1:0];
                    lost_one = |left_ext[2*bit_size-1:bit_size];
                end else if (sel == SEL_ASH) begin
                    result = $unsigned($signed(acc) >>> step);
                end else begin
                    result = acc >> step;
                end
            end
            SEL_ROT: begin
                // A zero step makes the complementary shift equal bit_size, which yields 0.
                if (direction == DIR_RIGHT) begin
                    result = (acc >> step) | (acc << (bit_size - step));
                end else begin
                    result = (acc << step) | (acc >> (bit_size - step));
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: executes shift counts wider than the datapath as repeated passes of <= bit_size-1 bits.
// Latency: result valid after ceil(amount/(bit_size-1)) RUN cycles; zero amount or illegal sel skip RUN.
// Backpressure: one command in flight; in_ready low until the result is taken, DONE holds while out_ready low.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int bit_size = 4,
    parameter int amt_w    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bit_size-1:0] in_data,
    input  logic [amt_w-1:0]    in_amount,
    input  logic                in_direction,
    input  logic [1:0]          in_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bit_size-1:0] out_data,
    output logic                out_overflow,
    output logic                busy
);

    localparam int               step_w   = $clog2(bit_size);
    localparam logic [amt_w-1:0] MAX_STEP = amt_w'(bit_size - 1);

    state_t              state, state_nxt;
    logic [bit_size-1:0] acc, acc_nxt;
    logic [amt_w-1:0]    remaining, remaining_nxt;
    logic                ovf, ovf_nxt;
    logic                dir_q, dir_nxt;
    logic [1:0]          sel_q, sel_nxt;

    logic [amt_w-1:0]    step_amt;
    logic [bit_size-1:0] pass_result;
    logic                pass_lost;

    assign step_amt = (remaining < MAX_STEP) ? remaining : MAX_STEP;

    shift_step #(
        .bit_size (bit_size),
        .step_w   (step_w)
    ) u_step (
        .acc       (acc),
        .step      (step_amt[step_w-1:0]),
        .direction (dir_q),
        .sel       (sel_q),
        .result    (pass_result),
        .lost_one  (pass_lost)
    );

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        remaining_nxt = remaining;
        ovf_nxt       = ovf;
        dir_nxt       = dir_q;
        sel_nxt       = sel_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt       = in_data;
                    remaining_nxt = in_amount;
                    ovf_nxt       = 1'b0;
                    dir_nxt       = in_direction;
                    sel_nxt       = in_sel;
                    if (in_sel == SEL_ILL) begin
                        acc_nxt   = '0;
                        state_nxt = DONE;
                    end else if (in_amount == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                acc_nxt       = pass_result;
                ovf_nxt       = ovf | pass_lost;
                remaining_nxt = remaining - step_amt;
                if (remaining_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
            dir_q     <= DIR_LEFT;
            sel_q     <= SEL_LSH;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= remaining_nxt;
            ovf       <= ovf_nxt;
            dir_q     <= dir_nxt;
            sel_q     <= sel_nxt;
        end
    end

    assign out_data     = acc;
    assign out_overflow = ovf;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose: scoreboard bench for shift_sequencer with directed corner cases plus randomized commands.
// Latency: expected output cycle is derived from the shift amount and checked on the rising out_valid.
// Backpressure: out_ready is randomized, and forced low for a window to test result holding.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int BW = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic [AW-1:0] in_amount = '0;
    logic          in_direction = 1'b0;
    logic [1:0]    in_sel = 2'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          out_overflow;
    logic          busy;

    shift_sequencer #(.bit_size(BW), .amt_w(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_amount    (in_amount),
        .in_direction (in_direction),
        .in_sel       (in_sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] d;
        logic          o;
        int unsigned   due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          hold_low = 0;
    logic        was_valid = 1'b0;
    logic        chk_ready_next = 1'b0;
    logic [BW-1:0] held_d = '0;
    logic          held_o = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [BW-1:0] d, input logic o, input int unsigned lat);
        exp_t e;
        e.d = d;
        e.o = o;
        e.due = lat;
        return e;
    endfunction

    // Reference: whole-amount shift semantics, independent of how the passes are split.
    function automatic exp_t model(input logic [BW-1:0] d, input logic [AW-1:0] a,
                                   input logic dir, input logic [1:0] sel);
        exp_t        e;
        int          n = int'(a);
        int          k = 0;
        int unsigned v = 32'(d);
        int unsigned mask = (32'd1 << BW) - 32'd1;
        int unsigned r = 0;
        e.o = 1'b0;
        if (sel == 2'd3) begin
            e.d = '0;
            e.due = 0;
            return e;
        end
        e.due = int'(unsigned'(n + BW - 2) / unsigned'(BW - 1));
        if (sel == 2'd2) begin
            k = n % BW;
            r = dir ? ((v >> k) | (v << (BW - k))) : ((v << k) | (v >> (BW - k)));
        end else if (!dir) begin
            r = (n >= BW) ? 0 : (v << n);
            e.o = (n >= BW) ? (v != 0) : ((v >> (BW - n)) != 0);
        end else if (sel == 2'd0) begin
            r = (n >= BW) ? 0 : (v >> n);
        end else if (d[BW-1]) begin
            r = (n >= BW) ? mask : ((v >> n) | (mask << (BW - n)));
        end else begin
            r = (n >= BW) ? 0 : (v >> n);
        end
        e.d = BW'(r & mask);
        return e;
    endfunction

    task automatic issue(input logic [BW-1:0] d, input logic [AW-1:0] a, input logic dir,
                         input logic [1:0] sel, input exp_t e, input bit expect_out);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready stuck at %0b, expected 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data = d;
        in_amount = a;
        in_direction = dir;
        in_sel = sel;
        if (expect_out) begin
            e.due = e.due + cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data = BW'($urandom);
        in_amount = AW'($urandom);
        in_direction = 1'($urandom);
        in_sel = 2'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !in_ready) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    // Monitor: owns out_ready so the handshake decision and the check see the same value.
    always @(negedge clk) begin
        if (hold_low > 0) begin
            out_ready = 1'b0;
            if (out_valid) hold_low--;
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!rst_n) begin
            was_valid = 1'b0;
            chk_ready_next = 1'b0;
        end else begin
            chk("ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (chk_ready_next) begin
                chk("ready_after_out", 32'(in_ready), 32'd1);
                chk_ready_next = 1'b0;
            end
            if (out_valid && !was_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: data %0h appeared, expected no output", out_data);
                end else begin
                    chk("latency", 32'(cyc), 32'(sb[0].due));
                end
                held_d = out_data;
                held_o = out_overflow;
            end else if (out_valid) begin
                chk("hold_data", 32'(out_data), 32'(held_d));
                chk("hold_ovf", 32'(out_overflow), 32'(held_o));
            end
            if (out_valid && out_ready) begin
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(mon_e.d));
                    chk("out_overflow", 32'(out_overflow), 32'(mon_e.o));
                end
                chk_ready_next = 1'b1;
            end
            was_valid = out_valid;
        end
    end

    initial begin
        logic [BW-1:0] rd;
        logic [AW-1:0] ra;
        logic          rdir;
        logic [1:0]    rsel;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_overflow", 32'(out_overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a command with reset during its second RUN cycle.
        issue(4'b1001, 8'd7, DIR_LEFT, SEL_LSH, mk('0, 1'b0, 0), 1'b0);
        @(negedge clk);
        chk("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_data", 32'(out_data), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_late_result", 32'(out_valid), 32'd0);

        issue(4'b1001, 8'd7, DIR_LEFT,  SEL_LSH, mk(4'b0000, 1'b1, 3), 1'b1);
        issue(4'b0001, 8'd5, DIR_RIGHT, SEL_ROT, mk(4'b1000, 1'b0, 2), 1'b1);
        issue(4'b1000, 8'd6, DIR_RIGHT, SEL_ASH, mk(4'b1111, 1'b0, 2), 1'b1);
        issue(4'b0110, 8'd0, DIR_LEFT,  SEL_LSH, mk(4'b0110, 1'b0, 0), 1'b1);
        issue(4'b1011, 8'd3, DIR_LEFT,  SEL_ILL, mk(4'b0000, 1'b0, 0), 1'b1);
        drain();

        hold_low = 5;
        issue(4'b0011, 8'd2, DIR_LEFT, SEL_LSH, mk(4'b1100, 1'b0, 1), 1'b1);
        drain();

        repeat (300) begin
            rd = BW'($urandom);
            ra = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 12));
            rdir = 1'($urandom);
            rsel = 2'($urandom);
            issue(rd, ra, rdir, rsel, model(rd, ra, rdir, rsel), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
